// File: rtl/coin_accumulator.sv
// Coin credit accumulator for a vending front end: collects coins up to MAX_CREDIT,
// presents a selection downstream, and refunds on cancel or idle timeout.
module coin_accumulator #(
  parameter logic [15:0] MAX_CREDIT  = 16'd5000,
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input  logic        I_CLK,
  input  logic        I_RESET_N,
  input  logic        I_COIN_VALID,
  input  logic [1:0]  I_COIN_TYPE,
  input  logic        I_SEL_VALID,
  input  logic [3:0]  I_SEL,
  input  logic        I_CANCEL,
  input  logic        I_READY,
  output logic        O_VALID,
  output logic [3:0]  O_SEL,
  output logic [15:0] O_CHANGE,
  output logic        O_COIN_REJECT,
  output logic        O_REFUND,
  output logic [15:0] O_REFUND_AMT,
  output logic        O_BUSY
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_PRESENT,
    S_REFUND
  } state_t;

  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYC - 1);

  state_t      state;
  logic [15:0] timer;

  logic [15:0] coin_value;
  logic [16:0] credit_sum;
  logic        coin_open;
  logic        coin_accept;
  logic        coin_reject;
  logic [15:0] credit_next;
  logic        sel_ok;
  logic        timed_out;

  always_comb begin
    coin_value = '0;
    case (I_COIN_TYPE)
      2'b00:   coin_value = 16'd5;
      2'b01:   coin_value = 16'd10;
      2'b10:   coin_value = 16'd25;
      default: coin_value = 16'd100;
    endcase
  end

  // O_CHANGE is the credit register; the sum is one bit wider so the limit compare never wraps
  always_comb begin
    credit_sum  = {1'b0, O_CHANGE} + {1'b0, coin_value};
    coin_open   = (state == S_IDLE) || (state == S_ACCUM);
    coin_accept = I_COIN_VALID && coin_open && (credit_sum <= {1'b0, MAX_CREDIT});
    coin_reject = I_COIN_VALID && !coin_accept;
    credit_next = coin_accept ? credit_sum[15:0] : O_CHANGE;
    sel_ok      = I_SEL_VALID && (I_SEL != 4'd0);
    timed_out   = (timer == TIMER_LAST) && !coin_accept;
  end

  always_ff @(posedge I_CLK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      state         <= S_IDLE;
      timer         <= '0;
      O_VALID       <= 1'b0;
      O_SEL         <= '0;
      O_CHANGE      <= '0;
      O_COIN_REJECT <= 1'b0;
      O_REFUND      <= 1'b0;
      O_REFUND_AMT  <= '0;
      O_BUSY        <= 1'b0;
    end else begin
      O_COIN_REJECT <= coin_reject;
      O_REFUND      <= 1'b0;
      O_REFUND_AMT  <= '0;
      case (state)
        S_IDLE: begin
          timer <= '0;
          if (coin_accept) begin
            O_CHANGE <= credit_next;
            O_BUSY   <= 1'b1;
            state    <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          O_CHANGE <= credit_next;
          // cancel beats selection; selection beats timeout; a same-cycle coin is already in credit_next
          if (I_CANCEL || (!sel_ok && timed_out)) begin
            O_REFUND     <= 1'b1;
            O_REFUND_AMT <= credit_next;
            timer        <= '0;
            state        <= S_REFUND;
          end else if (sel_ok) begin
            O_VALID <= 1'b1;
            O_SEL   <= I_SEL;
            timer   <= '0;
            state   <= S_PRESENT;
          end else if (coin_accept) begin
            timer <= '0;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        S_PRESENT: begin
          if (I_READY) begin
            O_VALID  <= 1'b0;
            O_SEL    <= '0;
            O_CHANGE <= '0;
            O_BUSY   <= 1'b0;
            state    <= S_IDLE;
          end
        end
        default: begin
          O_CHANGE <= '0;
          O_BUSY   <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_coin_accumulator.sv
// Bench for coin_accumulator: transaction-level model compared every cycle, plus directed literal checks.
module tb_coin_accumulator;

  localparam int unsigned TMO  = 8;
  localparam int          MAXC = 5000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        coin_valid = 1'b0;
  logic [1:0]  coin_type = '0;
  logic        sel_valid = 1'b0;
  logic [3:0]  sel = '0;
  logic        cancel = 1'b0;
  logic        ready = 1'b0;

  logic        o_valid;
  logic [3:0]  o_sel;
  logic [15:0] o_change;
  logic        o_coin_reject;
  logic        o_refund;
  logic [15:0] o_refund_amt;
  logic        o_busy;

  int checks = 0;
  int passes = 0;

  coin_accumulator #(.MAX_CREDIT(16'd5000), .TIMEOUT_CYC(TMO)) dut (
    .I_CLK(clk), .I_RESET_N(rst_n),
    .I_COIN_VALID(coin_valid), .I_COIN_TYPE(coin_type),
    .I_SEL_VALID(sel_valid), .I_SEL(sel), .I_CANCEL(cancel), .I_READY(ready),
    .O_VALID(o_valid), .O_SEL(o_sel), .O_CHANGE(o_change),
    .O_COIN_REJECT(o_coin_reject), .O_REFUND(o_refund),
    .O_REFUND_AMT(o_refund_amt), .O_BUSY(o_busy)
  );

  always #5 clk = ~clk;

  // phase: 0 waiting, 1 collecting, 2 presenting, 3 refunding; idle = coinless collecting cycles
  typedef struct {
    int phase;
    int credit;
    int idle;
    int sel;
    bit rej;
    bit refund;
    int amt;
  } model_t;

  model_t m = '{0, 0, 0, 0, 1'b0, 1'b0, 0};

  function automatic model_t advance(model_t c);
    model_t n = c;
    int value;
    bit take;
    case (coin_type)
      2'd0:    value = 5;
      2'd1:    value = 10;
      2'd2:    value = 25;
      default: value = 100;
    endcase
    take     = coin_valid && (c.phase == 0 || c.phase == 1) && (c.credit + value <= MAXC);
    n.rej    = coin_valid && !take;
    n.refund = 1'b0;
    n.amt    = 0;
    case (c.phase)
      0: if (take) begin n.credit = value; n.phase = 1; n.idle = 0; end
      1: begin
        if (take) n.credit = c.credit + value;
        if (cancel) begin
          n.refund = 1'b1; n.amt = n.credit; n.phase = 3;
        end else if (sel_valid && sel != 4'd0) begin
          n.phase = 2; n.sel = int'(sel);
        end else if (take) begin
          n.idle = 0;
        end else begin
          n.idle = c.idle + 1;
          if (n.idle == int'(TMO)) begin n.refund = 1'b1; n.amt = n.credit; n.phase = 3; end
        end
      end
      2: if (ready) begin n.phase = 0; n.credit = 0; n.sel = 0; end
      default: begin n.phase = 0; n.credit = 0; end
    endcase
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '{0, 0, 0, 0, 1'b0, 1'b0, 0};
    else        m <= advance(m);
  end

  logic [39:0] got_v, exp_v;
  always_comb begin
    got_v = {o_valid, o_sel, o_change, o_coin_reject, o_refund, o_refund_amt, o_busy};
    exp_v = {m.phase == 2, 4'(m.sel), 16'(m.credit), m.rej, m.refund, 16'(m.amt), m.phase != 0};
  end

  always @(negedge clk) begin
    checks++;
    if (got_v === exp_v) passes++;
    else $display("FAIL cycle_compare t=%0t got v=%b sel=%0d chg=%0d rej=%b ref=%b amt=%0d busy=%b expected v=%b sel=%0d chg=%0d rej=%b ref=%b amt=%0d busy=%b",
                  $time, o_valid, o_sel, o_change, o_coin_reject, o_refund, o_refund_amt, o_busy,
                  exp_v[39], exp_v[38:35], exp_v[34:19], exp_v[18], exp_v[17], exp_v[16:1], exp_v[0]);
  end

  task automatic lit(input string name, input int got, input int expv);
    checks++;
    if (got == expv) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, got, expv);
  endtask

  task automatic step(input bit cv, input bit [1:0] ct, input bit sv, input bit [3:0] s,
                      input bit cn, input bit rd);
    coin_valid = cv; coin_type = ct; sel_valid = sv; sel = s; cancel = cn; ready = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic build_4950();
    for (int i = 0; i < 49; i++) step(1, 3, 0, 0, 0, 0);
    step(1, 2, 0, 0, 0, 0);
    step(1, 2, 0, 0, 0, 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    lit("rst_valid", int'(o_valid), 0);
    lit("rst_change", int'(o_change), 0);
    lit("rst_busy", int'(o_busy), 0);
    rst_n = 1'b1;
    idle(1);

    // 25 + 25 + 100, select item 3 with ready high
    step(1, 2, 0, 0, 0, 0);
    step(1, 2, 0, 0, 0, 0);
    step(1, 3, 0, 0, 0, 0);
    lit("acc_change150", int'(o_change), 150);
    lit("model_change150", m.credit, 150);
    step(0, 0, 1, 3, 0, 1);
    lit("sel_valid", int'(o_valid), 1);
    lit("sel_code", int'(o_sel), 3);
    lit("sel_change", int'(o_change), 150);
    step(0, 0, 0, 0, 0, 1);
    lit("done_valid", int'(o_valid), 0);
    lit("done_change", int'(o_change), 0);
    lit("done_busy", int'(o_busy), 0);

    // limit handling around MAX_CREDIT
    build_4950();
    lit("build_4950", int'(o_change), 4950);
    step(1, 3, 0, 0, 0, 0);
    lit("over_reject", int'(o_coin_reject), 1);
    lit("over_hold", int'(o_change), 4950);
    step(1, 2, 0, 0, 0, 0);
    lit("after_rej_pulse", int'(o_coin_reject), 0);
    lit("chg_4975", int'(o_change), 4975);
    step(1, 2, 0, 0, 0, 0);
    lit("chg_max", int'(o_change), 5000);
    step(1, 0, 0, 0, 0, 0);
    lit("at_max_reject", int'(o_coin_reject), 1);
    step(0, 0, 0, 0, 1, 0);
    lit("cancel_amt_max", int'(o_refund_amt), 5000);
    idle(1);

    // same-cycle coin and cancel at credit 20
    step(1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 0);
    lit("coin_cancel_ref", int'(o_refund), 1);
    lit("coin_cancel_amt", int'(o_refund_amt), 25);
    lit("model_amt25", m.amt, 25);
    idle(1);
    lit("post_refund_busy", int'(o_busy), 0);
    lit("post_refund_amt", int'(o_refund_amt), 0);

    // PRESENT stalls on ready low; coin rejected, cancel ignored
    step(1, 2, 0, 0, 0, 0);
    step(0, 0, 1, 7, 0, 0);
    step(1, 3, 0, 0, 0, 0);
    lit("present_reject", int'(o_coin_reject), 1);
    step(0, 0, 0, 0, 1, 0);
    lit("present_no_refund", int'(o_refund), 0);
    idle(3);
    lit("stall_valid", int'(o_valid), 1);
    lit("stall_sel", int'(o_sel), 7);
    lit("stall_change", int'(o_change), 25);
    step(0, 0, 0, 0, 0, 1);
    lit("stall_release", int'(o_valid), 0);

    // selection of item 0 is ignored; cancel wins over a same-cycle selection
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    lit("sel0_valid", int'(o_valid), 0);
    lit("sel0_busy", int'(o_busy), 1);
    step(0, 0, 1, 4, 1, 0);
    lit("prio_refund", int'(o_refund), 1);
    lit("prio_valid", int'(o_valid), 0);
    idle(1);
    step(0, 0, 1, 5, 1, 1);
    lit("idle_ignore_busy", int'(o_busy), 0);

    // idle timeout refunds after TMO coinless cycles
    step(1, 1, 0, 0, 0, 0);
    idle(int'(TMO) - 1);
    lit("tmo_early", int'(o_refund), 0);
    idle(1);
    lit("tmo_refund", int'(o_refund), 1);
    lit("tmo_amt", int'(o_refund_amt), 10);
    idle(1);
    lit("tmo_busy", int'(o_busy), 0);

    // an accepted coin restarts the timer
    step(1, 1, 0, 0, 0, 0);
    idle(5);
    step(1, 0, 0, 0, 0, 0);
    idle(int'(TMO) - 1);
    lit("restart_early", int'(o_refund), 0);
    idle(1);
    lit("restart_amt", int'(o_refund_amt), 15);
    idle(1);

    // a rejected coin does not restart the timer
    build_4950();
    idle(3);
    step(1, 3, 0, 0, 0, 0);
    idle(3);
    lit("rejtmr_early", int'(o_refund), 0);
    idle(1);
    lit("rejtmr_refund", int'(o_refund), 1);
    lit("rejtmr_amt", int'(o_refund_amt), 4950);
    idle(1);

    // reset in PRESENT clears everything at once, no refund
    step(1, 2, 0, 0, 0, 0);
    step(0, 0, 1, 9, 0, 0);
    lit("pre_rst_valid", int'(o_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    lit("async_valid", int'(o_valid), 0);
    lit("async_sel", int'(o_sel), 0);
    lit("async_change", int'(o_change), 0);
    lit("async_busy", int'(o_busy), 0);
    lit("async_refund", int'(o_refund), 0);
    idle(2);
    rst_n = 1'b1;
    step(1, 0, 0, 0, 0, 0);
    lit("post_rst_credit", int'(o_change), 5);
    lit("post_rst_no_refund", int'(o_refund), 0);
    idle(2);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
